// File: rtl/stream_hasher_if.sv
// stream_hasher_if: base-input and hash-output valid/ready streams of the k-mer hasher.
interface stream_hasher_if #(
   parameter int LOG2_NUM_OF_BUCKETS = 8,
   parameter int POS_W = 16
);
   logic in_valid;
   logic in_ready;
   logic [1:0] in_base;
   logic in_sop;
   logic out_valid;
   logic out_ready;
   logic [31:0] out_h1;
   logic [LOG2_NUM_OF_BUCKETS-1:0] out_h2;
   logic [POS_W-1:0] out_pos;
   modport master (
      output in_valid, in_base, in_sop, out_ready,
      input in_ready, out_valid, out_h1, out_h2, out_pos
   );
   modport slave (
      input in_valid, in_base, in_sop, out_ready,
      output in_ready, out_valid, out_h1, out_h2, out_pos
   );
endinterface

// File: rtl/stream_hasher.sv
// stream_hasher: two-stage pipelined sliding-window k-mer hasher with bucket index.
// Define STREAM_HASHER_CANONICAL_EN to hash min(forward, reverse-complement) instead of forward.
module stream_hasher #(
   parameter int KMER_SIZE = 16,
   parameter int LOG2_NUM_OF_BUCKETS = 8,
   parameter int NUM_OF_BUCKETS = 256,
   parameter logic [31:0] HASH_MULT = 32'h9E3779B1,
   parameter int POS_W = 16
) (
   input logic clk,
   input logic rst_n,
   stream_hasher_if.slave s
);
   localparam int W = 2 * KMER_SIZE;
   localparam int NW = (W + 31) / 32;
   localparam int CW = $clog2(KMER_SIZE + 1);
   typedef enum logic {FILL, RUN} state_t;
   state_t st;
   logic [W-1:0] win, win_n, key;
   logic [CW-1:0] cnt, cnt_n;
   logic [POS_W-1:0] idx, idx_n, s1_pos;
   logic [31:0] s1_fold, prod;
   logic s1_valid, s2_load, acc, start;
   if (LOG2_NUM_OF_BUCKETS < 31 && NUM_OF_BUCKETS != (1 << LOG2_NUM_OF_BUCKETS)) begin : g_bad_buckets
      $error("NUM_OF_BUCKETS must equal 2**LOG2_NUM_OF_BUCKETS");
   end
   function automatic logic [31:0] fold32(input logic [W-1:0] x);
      logic [NW*32-1:0] z;
      z = (NW * 32)'(x);
      fold32 = '0;
      for (int i = 0; i < NW; i++) fold32 ^= z[i*32 +: 32];
   endfunction
   assign s2_load = !s.out_valid || s.out_ready;
   assign s.in_ready = !s1_valid || s2_load;
   assign acc = s.in_valid && s.in_ready;
   // an empty counter means no sequence has started, so the base acts as sop
   assign start = s.in_sop || cnt == '0;
   assign win_n = start ? W'(s.in_base) : (win << 2) | W'(s.in_base);
   assign cnt_n = start ? CW'(1) : (st == RUN ? cnt : cnt + CW'(1));
   assign idx_n = start ? '0 : idx + POS_W'(1);
   assign prod = s1_fold * HASH_MULT;
`ifdef STREAM_HASHER_CANONICAL_EN
   localparam logic [W-1:0] ONES = '1;
   logic [W-1:0] rc, rc_n;
   logic [1:0] nb;
   assign nb = ~s.in_base;
   // complement of a cleared window is all ones; newest complemented base enters at the MSBs
   assign rc_n = (start ? ONES >> 2 : rc >> 2) | (W'(nb) << (W - 2));
   assign key = win_n < rc_n ? win_n : rc_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rc <= ONES;
      else if (acc) rc <= rc_n;
`else
   assign key = win_n;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= FILL;
         win <= '0;
         cnt <= '0;
         idx <= '0;
         s1_valid <= 1'b0;
         s1_fold <= '0;
         s1_pos <= '0;
         s.out_valid <= 1'b0;
         s.out_h1 <= '0;
         s.out_h2 <= '0;
         s.out_pos <= '0;
      end else begin
         if (acc) begin
            win <= win_n;
            cnt <= cnt_n;
            idx <= idx_n;
            st <= cnt_n == CW'(KMER_SIZE) ? RUN : FILL;
         end
         if (s.in_ready) begin
            s1_valid <= acc && cnt_n == CW'(KMER_SIZE);
            s1_fold <= fold32(key);
            s1_pos <= idx_n - POS_W'(KMER_SIZE - 1);
         end
         if (s2_load) begin
            s.out_valid <= s1_valid;
            if (s1_valid) begin
               s.out_h1 <= prod;
               s.out_h2 <= prod[31 -: LOG2_NUM_OF_BUCKETS];
               s.out_pos <= s1_pos;
            end
         end
      end
endmodule

// File: tb/tb_stream_hasher.sv
// tb_stream_hasher: scoreboard bench for stream_hasher (K=16, 256 buckets).
module tb_stream_hasher;
   localparam int K = 16;
   localparam logic [31:0] MULT = 32'h9E3779B1;
   typedef struct packed {
      logic [31:0] h1;
      logic [7:0] h2;
      logic [15:0] pos;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int ncmp = 0, nfail = 0, cyc = 0, last_acc = 0, started = 0, blen = 0;
   exp_t exp_q[$];
   int out_cyc[$];
   logic [1:0] seq[$];
   logic [63:0] pat = 64'h1B2DE4C39F067A51;
   logic saw_nr;
   stream_hasher_if #(.LOG2_NUM_OF_BUCKETS(8), .POS_W(16)) b();
   stream_hasher dut (.clk(clk), .rst_n(rst_n), .s(b));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask
   // reference: forward / reverse-complement k-mer built from the last K bases
   function automatic exp_t model();
      logic [63:0] p, r, key;
      logic [1:0] t;
      logic [31:0] h;
      p = '0;
      r = '0;
      for (int i = 0; i < K; i++) begin
         p = (p << 2) | 64'(seq[i]);
         t = ~seq[K-1-i];
         r = (r << 2) | 64'(t);
      end
`ifdef STREAM_HASHER_CANONICAL_EN
      key = p < r ? p : r;
`else
      key = p;
`endif
      h = (key[31:0] ^ key[63:32]) * MULT;
      return exp_t'{h1: h, h2: h[31:24], pos: 16'(blen - K)};
   endfunction
   function automatic logic [1:0] pb(input int i);
      return pat[2*(i%32) +: 2];
   endfunction
   task automatic send(input logic [1:0] bs, input logic sp, input logic he = 1'b0, input exp_t e = '0);
      int n = 0;
      b.in_valid = 1'b1;
      b.in_base = bs;
      b.in_sop = sp;
      #4;
      while (!b.in_ready && n < 100) begin
         @(negedge clk);
         #4;
         n++;
      end
      if (!b.in_ready) begin
         ncmp++;
         nfail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end else begin
         if (sp || started == 0) begin
            seq.delete();
            blen = 0;
            started = 1;
         end
         seq.push_back(bs);
         blen++;
         if (seq.size() > K) void'(seq.pop_front());
         if (seq.size() == K) exp_q.push_back(he ? e : model());
         last_acc = cyc;
      end
      @(negedge clk);
      b.in_valid = 1'b0;
      b.in_sop = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask
   initial begin : monitor
      exp_t prev, got, req;
      logic have_prev;
      have_prev = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            have_prev = 1'b0;
            continue;
         end
         got = exp_t'{h1: b.out_h1, h2: b.out_h2, pos: b.out_pos};
         if (have_prev) chk("stall_stable", {b.out_valid, got}, {1'b1, prev});
         have_prev = b.out_valid && !b.out_ready;
         prev = got;
         if (b.out_valid && b.out_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               ncmp++;
               nfail++;
               $display("FAIL unexpected_result: got h1=0x%0h pos=%0d, required none", got.h1, got.pos);
            end else begin
               req = exp_q.pop_front();
               chk("out_h1", got.h1, req.h1);
               chk("out_h2", 32'(got.h2), 32'(req.h2));
               chk("out_pos", 32'(got.pos), 32'(req.pos));
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int c_acc;
      b.in_valid = 1'b0;
      b.in_base = 2'd0;
      b.in_sop = 1'b0;
      b.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_out_valid", 32'(b.out_valid), 0);
      chk("rst_out_h1", b.out_h1, 0);
      chk("rst_out_h2", 32'(b.out_h2), 0);
      chk("rst_out_pos", 32'(b.out_pos), 0);
      chk("rst_in_ready", 32'(b.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // sop + 15 A + C -> packed=1, then one more A -> packed=4
      out_cyc.delete();
      send(2'd0, 1'b1);
      for (int i = 0; i < 14; i++) send(2'd0, 1'b0);
      send(2'd1, 1'b0, 1'b1, exp_t'{h1: 32'h9E3779B1, h2: 8'd158, pos: 16'd0});
      c_acc = last_acc;
      send(2'd0, 1'b0, 1'b1, exp_t'{h1: 32'h78DDE6C4, h2: 8'd120, pos: 16'd1});
      drain();
      chk("first_pair_count", out_cyc.size(), 2);
      if (out_cyc.size() == 2) begin
         chk("latency", out_cyc[0] - c_acc, 2);
         chk("back_to_back", out_cyc[1] - out_cyc[0], 1);
      end
      // 16 T bases
      send(2'd3, 1'b1);
      for (int i = 0; i < 14; i++) send(2'd3, 1'b0);
`ifdef STREAM_HASHER_CANONICAL_EN
      send(2'd3, 1'b0, 1'b1, exp_t'{h1: 32'h0, h2: 8'd0, pos: 16'd0});
`else
      send(2'd3, 1'b0, 1'b1, exp_t'{h1: 32'h61C8864F, h2: 8'd97, pos: 16'd0});
`endif
      drain();
      // continuous stream with a 5-cycle output stall
      saw_nr = 1'b0;
      fork
         begin
            send(pb(0), 1'b1);
            for (int i = 1; i < 30; i++) send(pb(i), 1'b0);
         end
         begin
            repeat (20) @(negedge clk);
            b.out_ready = 1'b0;
            repeat (5) begin
               #3;
               if (!b.in_ready) saw_nr = 1'b1;
               @(negedge clk);
            end
            b.out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_in_ready_drop", 32'(saw_nr), 1);
      // new sop after 20 bases restarts fill and position
      send(pb(3), 1'b1);
      for (int i = 1; i < 20; i++) send(pb(i + 7), 1'b0);
      send(pb(5), 1'b1);
      for (int i = 1; i < 20; i++) send(pb(i + 11), 1'b0);
      drain();
      // reset while two results are in flight
      send(2'd2, 1'b1);
      for (int i = 0; i < 16; i++) send(pb(i + 2), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(b.out_valid), 0);
      chk("async_rst_in_ready", 32'(b.in_ready), 1);
      exp_q.delete();
      started = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // first base after reset without sop acts as sop
      for (int i = 0; i < 15; i++) send(2'd0, 1'b0);
      send(2'd1, 1'b0, 1'b1, exp_t'{h1: 32'h9E3779B1, h2: 8'd158, pos: 16'd0});
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
